// File: rtl/hdmi_pkg.sv
// Shared constants for the HDMI video output path: 1080p60 timing defaults,
// pixel width and the generator state encoding.
package hdmi_pkg;

   localparam int PIXEL_W = 24;

   localparam int DEF_H_ACTIVE = 1920;
   localparam int DEF_H_FP     = 88;
   localparam int DEF_H_SYNC   = 44;
   localparam int DEF_H_BP     = 148;

   localparam int DEF_V_ACTIVE = 1080;
   localparam int DEF_V_FP     = 4;
   localparam int DEF_V_SYNC   = 5;
   localparam int DEF_V_BP     = 36;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } vid_state_t;

   function automatic int cnt_width(input int total);
      return (total > 1) ? $clog2(total) : 1;
   endfunction

   function automatic logic in_window(input int pos, input int lo, input int len);
      return (pos >= lo) && (pos < lo + len);
   endfunction

endpackage

// File: rtl/hdmi_timing_gen.sv
// Raster timing generator: IDLE/RUN control, h/v counters and region decode.
// Outputs are registered and describe the position the counters hold this cycle.
module hdmi_timing_gen
   import hdmi_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   output logic active,
   output logic hsync,
   output logic vsync,
   output logic first_pixel
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = cnt_width(H_TOTAL);
   localparam int VW      = cnt_width(V_TOTAL);

   vid_state_t    state;
   vid_state_t    state_next;
   logic [HW-1:0] h_cnt;
   logic [HW-1:0] h_next;
   logic [VW-1:0] v_cnt;
   logic [VW-1:0] v_next;
   logic          run_next;
   logic          act_next;
   logic          hs_next;
   logic          vs_next;
   logic          first_next;

   // A stop request is only honoured on the last pixel of the frame, so a
   // frame that has started is always completed.
   always_comb begin
      state_next = state;
      h_next     = h_cnt;
      v_next     = v_cnt;
      case (state)
         ST_IDLE: begin
            h_next = '0;
            v_next = '0;
            if (enable) state_next = ST_RUN;
         end
         ST_RUN: begin
            if (h_cnt == HW'(H_TOTAL - 1)) begin
               h_next = '0;
               if (v_cnt == VW'(V_TOTAL - 1)) begin
                  v_next = '0;
                  if (!enable) state_next = ST_IDLE;
               end else begin
                  v_next = v_cnt + 1'b1;
               end
            end else begin
               h_next = h_cnt + 1'b1;
            end
         end
         default: begin
            state_next = ST_IDLE;
            h_next     = '0;
            v_next     = '0;
         end
      endcase
   end

   always_comb begin
      run_next   = (state_next == ST_RUN);
      act_next   = run_next && in_window(int'(h_next), 0, H_ACTIVE)
                            && in_window(int'(v_next), 0, V_ACTIVE);
      hs_next    = run_next && in_window(int'(h_next), H_ACTIVE + H_FP, H_SYNC);
      vs_next    = run_next && in_window(int'(v_next), V_ACTIVE + V_FP, V_SYNC);
      first_next = run_next && (h_next == '0) && (v_next == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         h_cnt       <= '0;
         v_cnt       <= '0;
         active      <= 1'b0;
         hsync       <= 1'b0;
         vsync       <= 1'b0;
         first_pixel <= 1'b0;
      end else begin
         state       <= state_next;
         h_cnt       <= h_next;
         v_cnt       <= v_next;
         active      <= act_next;
         hsync       <= hs_next;
         vsync       <= vs_next;
         first_pixel <= first_next;
      end
   end

endmodule

// File: rtl/hdmi_video_out.sv
// HDMI video output stage: issues pixel requests upstream, captures returned
// pixels two cycles later alongside delayed timing, and tracks underflows.
module hdmi_video_out
   import hdmi_pkg::*;
#(
   parameter int               H_ACTIVE        = DEF_H_ACTIVE,
   parameter int               H_FP            = DEF_H_FP,
   parameter int               H_SYNC          = DEF_H_SYNC,
   parameter int               H_BP            = DEF_H_BP,
   parameter int               V_ACTIVE        = DEF_V_ACTIVE,
   parameter int               V_FP            = DEF_V_FP,
   parameter int               V_SYNC          = DEF_V_SYNC,
   parameter int               V_BP            = DEF_V_BP,
   parameter bit               HS_POL          = 1'b1,
   parameter bit               VS_POL          = 1'b1,
   parameter logic [PIXEL_W-1:0] UNDERFLOW_COLOR = 24'h000000
) (
   input  logic               tx_clock,
   input  logic               tx_rst_n,
   input  logic               enable,
   output logic               tx_req_out,
   input  logic [PIXEL_W-1:0] tx_data,
   input  logic               tx_data_valid,
   output logic [PIXEL_W-1:0] vid_data,
   output logic               vid_de,
   output logic               vid_hsync,
   output logic               vid_vsync,
   output logic               frame_start,
   output logic               underflow_sticky,
   output logic [15:0]        underflow_count,
   input  logic               underflow_clr
);

   logic pos_active;
   logic pos_hsync;
   logic pos_vsync;
   logic pos_first;
   logic de_d1;
   logic hs_d1;
   logic vs_d1;
   logic fs_d1;
   logic underflow_event;

   hdmi_timing_gen #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP)
   ) u_timing (
      .clk         (tx_clock),
      .rst_n       (tx_rst_n),
      .enable      (enable),
      .active      (pos_active),
      .hsync       (pos_hsync),
      .vsync       (pos_vsync),
      .first_pixel (pos_first)
   );

   // The request is a flop inside the timing generator, aligned to the counters.
   assign tx_req_out = pos_active;

   // Stage 1 lines up with the cycle the upstream returns the requested pixel.
   always_ff @(posedge tx_clock or negedge tx_rst_n) begin
      if (!tx_rst_n) begin
         de_d1 <= 1'b0;
         hs_d1 <= 1'b0;
         vs_d1 <= 1'b0;
         fs_d1 <= 1'b0;
      end else begin
         de_d1 <= pos_active;
         hs_d1 <= pos_hsync;
         vs_d1 <= pos_vsync;
         fs_d1 <= pos_first;
      end
   end

   always_ff @(posedge tx_clock or negedge tx_rst_n) begin
      if (!tx_rst_n) begin
         vid_de      <= 1'b0;
         vid_hsync   <= ~HS_POL;
         vid_vsync   <= ~VS_POL;
         frame_start <= 1'b0;
         vid_data    <= '0;
      end else begin
         vid_de      <= de_d1;
         vid_hsync   <= hs_d1 ? HS_POL : ~HS_POL;
         vid_vsync   <= vs_d1 ? VS_POL : ~VS_POL;
         frame_start <= fs_d1;
         if (de_d1) vid_data <= tx_data_valid ? tx_data : UNDERFLOW_COLOR;
         else       vid_data <= '0;
      end
   end

   assign underflow_event = de_d1 && !tx_data_valid;

   // Software clear wins over an underflow landing in the same cycle.
   always_ff @(posedge tx_clock or negedge tx_rst_n) begin
      if (!tx_rst_n) begin
         underflow_sticky <= 1'b0;
         underflow_count  <= '0;
      end else if (underflow_clr) begin
         underflow_sticky <= 1'b0;
         underflow_count  <= '0;
      end else if (underflow_event) begin
         underflow_sticky <= 1'b1;
         if (underflow_count != 16'hFFFF) underflow_count <= underflow_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_hdmi_video_out.sv
// Directed bench for hdmi_video_out on a tiny 8x5 raster, plus a dense raster
// instance used only to drive the underflow counter into saturation.
module tb_hdmi_video_out;

   localparam logic [23:0] UF_COLOR = 24'hABCDEF;
   localparam logic [23:0] BASE     = 24'h112233;

   logic        tx_clock = 1'b0;
   logic        tx_rst_n;
   logic        enable;
   logic        tx_req_out;
   logic [23:0] tx_data;
   logic        tx_data_valid;
   logic [23:0] vid_data;
   logic        vid_de;
   logic        vid_hsync;
   logic        vid_vsync;
   logic        frame_start;
   logic        underflow_sticky;
   logic [15:0] underflow_count;
   logic        underflow_clr;

   logic        rst2_n;
   logic        enable2;
   logic        req2;
   logic [23:0] vid_data2;
   logic        de2;
   logic        hs2;
   logic        vs2;
   logic        fs2;
   logic        sticky2;
   logic [15:0] count2;

   always #5 tx_clock = ~tx_clock;

   hdmi_video_out #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b1), .UNDERFLOW_COLOR(UF_COLOR)
   ) u_dut (
      .tx_clock         (tx_clock),
      .tx_rst_n         (tx_rst_n),
      .enable           (enable),
      .tx_req_out       (tx_req_out),
      .tx_data          (tx_data),
      .tx_data_valid    (tx_data_valid),
      .vid_data         (vid_data),
      .vid_de           (vid_de),
      .vid_hsync        (vid_hsync),
      .vid_vsync        (vid_vsync),
      .frame_start      (frame_start),
      .underflow_sticky (underflow_sticky),
      .underflow_count  (underflow_count),
      .underflow_clr    (underflow_clr)
   );

   hdmi_video_out #(
      .H_ACTIVE(200), .H_FP(1), .H_SYNC(1), .H_BP(1),
      .V_ACTIVE(200), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .UNDERFLOW_COLOR(UF_COLOR)
   ) u_dut_sat (
      .tx_clock         (tx_clock),
      .tx_rst_n         (rst2_n),
      .enable           (enable2),
      .tx_req_out       (req2),
      .tx_data          (24'h000000),
      .tx_data_valid    (1'b0),
      .vid_data         (vid_data2),
      .vid_de           (de2),
      .vid_hsync        (hs2),
      .vid_vsync        (vs2),
      .frame_start      (fs2),
      .underflow_sticky (sticky2),
      .underflow_count  (count2),
      .underflow_clr    (1'b0)
   );

   typedef struct {
      logic [3:0] hold;
      logic [7:0] de;
      logic [7:0] hs;
      logic       vs;
      int         uf;
   } line_vec_t;

   line_vec_t   lines [5];
   logic [23:0] exp_q [$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          req_n = 0;
   bit          prev_req = 1'b0;
   bit          hold_first = 1'b0;
   bit          hold_all = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic bit withheld(input int n);
      if (hold_all) return 1'b1;
      if (hold_first && n < 8) return lines[n / 4].hold[n % 4];
      return 1'b0;
   endfunction

   // Upstream model: answers the previous cycle's request, otherwise drives
   // junk with valid high so the DUT must ignore it.
   task automatic tick();
      bit w;
      @(negedge tx_clock);
      if (prev_req) begin
         w             = withheld(req_n);
         tx_data       = BASE + 24'(req_n);
         tx_data_valid = !w;
         exp_q.push_back(w ? UF_COLOR : BASE + 24'(req_n));
         req_n++;
      end else begin
         tx_data       = 24'hDEAD00;
         tx_data_valid = 1'b1;
      end
      prev_req = tx_req_out;
   endtask

   task automatic wait_frame_start(output bit found, output int req_at, output int fs_at);
      found  = 1'b0;
      req_at = -1;
      fs_at  = -1;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (tx_req_out && req_at < 0) req_at = i;
         if (frame_start) begin
            found = 1'b1;
            fs_at = i;
            break;
         end
      end
   endtask

   task automatic check_pos(input int l, input int h, input bit last);
      int  k2;
      logic exp_req;
      k2 = l * 8 + h + 2;
      if (k2 >= 40) exp_req = last ? 1'b0 : lines[0].de[k2 - 40];
      else          exp_req = lines[k2 / 8].de[k2 % 8];
      check("vid_de", 32'(vid_de), 32'(lines[l].de[h]));
      check("vid_hsync", 32'(vid_hsync), 32'(lines[l].hs[h]));
      check("vid_vsync", 32'(vid_vsync), 32'(lines[l].vs));
      check("frame_start", 32'(frame_start), 32'(l == 0 && h == 0));
      check("tx_req_out", 32'(tx_req_out), 32'(exp_req));
      if (vid_de) begin
         if (exp_q.size() == 0) check("vid_data_pending", 32'(vid_data), 32'hFFFFFFFF);
         else                   check("vid_data", 32'(vid_data), 32'(exp_q.pop_front()));
      end else begin
         check("vid_data_blank", 32'(vid_data), 32'h0);
      end
   endtask

   task automatic run_frame(input bit need_tick, input bit last, input bit chk_uf);
      for (int l = 0; l < 5; l++) begin
         for (int h = 0; h < 8; h++) begin
            if (need_tick || l != 0 || h != 0) tick();
            check_pos(l, h, last);
            if (chk_uf && h == 7) check("underflow_count_line", 32'(underflow_count), 32'(lines[l].uf));
            if (last && l == 1 && h == 2) enable = 1'b0;
         end
      end
   endtask

   task automatic applyStimulus();
      bit found;
      int req_at;
      int fs_at;
      bit saw_req;
      bit saw_de;
      bit saw_hs;
      bit saw_fs;

      // Reset values while reset is held from time zero.
      #12;
      check("rst_req", 32'(tx_req_out), 32'h0);
      check("rst_de", 32'(vid_de), 32'h0);
      check("rst_hsync", 32'(vid_hsync), 32'h0);
      check("rst_vsync", 32'(vid_vsync), 32'h0);
      check("rst_data", 32'(vid_data), 32'h0);
      check("rst_fs", 32'(frame_start), 32'h0);
      check("rst_sticky", 32'(underflow_sticky), 32'h0);
      check("rst_count", 32'(underflow_count), 32'h0);

      @(negedge tx_clock);
      tx_rst_n = 1'b1;
      rst2_n   = 1'b1;
      enable2  = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      check("idle_req", 32'(tx_req_out), 32'h0);
      check("idle_de", 32'(vid_de), 32'h0);

      // Frame 1 withholds pixels 5..7, frames 2 and 3 run clean, frame 3 stops.
      hold_first = 1'b1;
      enable     = 1'b1;
      wait_frame_start(found, req_at, fs_at);
      check("fs_found_1", 32'(found), 32'h1);
      check("first_req_cycle", 32'(req_at), 32'h0);
      check("req_to_de_latency", 32'(fs_at - req_at), 32'h2);
      run_frame(1'b0, 1'b0, 1'b1);
      check("sticky_after_f1", 32'(underflow_sticky), 32'h1);
      hold_first = 1'b0;
      run_frame(1'b1, 1'b0, 1'b0);
      run_frame(1'b1, 1'b1, 1'b0);

      saw_req = 1'b0; saw_de = 1'b0; saw_hs = 1'b0; saw_fs = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         saw_req |= tx_req_out;
         saw_de  |= vid_de;
         saw_hs  |= vid_hsync;
         saw_fs  |= frame_start;
      end
      check("stopped_req", 32'(saw_req), 32'h0);
      check("stopped_de", 32'(saw_de), 32'h0);
      check("stopped_hsync", 32'(saw_hs), 32'h0);
      check("stopped_fs", 32'(saw_fs), 32'h0);
      check("count_kept", 32'(underflow_count), 32'h3);

      underflow_clr = 1'b1;
      tick();
      underflow_clr = 1'b0;
      check("clr_sticky", 32'(underflow_sticky), 32'h0);
      check("clr_count", 32'(underflow_count), 32'h0);
   endtask

   task automatic checkOutput();
      bit found;
      int req_at;
      int fs_at;

      // Clear held through a frame of nothing but underflows.
      hold_all      = 1'b1;
      underflow_clr = 1'b1;
      enable        = 1'b1;
      wait_frame_start(found, req_at, fs_at);
      check("fs_found_2", 32'(found), 32'h1);
      run_frame(1'b0, 1'b1, 1'b0);
      check("clr_prio_sticky", 32'(underflow_sticky), 32'h0);
      check("clr_prio_count", 32'(underflow_count), 32'h0);
      underflow_clr = 1'b0;
      for (int i = 0; i < 4; i++) tick();

      // Reset hits on the first active pixel of a fresh frame.
      enable = 1'b1;
      wait_frame_start(found, req_at, fs_at);
      check("fs_found_3", 32'(found), 32'h1);
      check("pre_rst_de", 32'(vid_de), 32'h1);
      check("pre_rst_count", 32'(underflow_count), 32'h1);
      check("pre_rst_data", 32'(vid_data), 32'(UF_COLOR));
      #2 tx_rst_n = 1'b0;
      #1;
      check("arst_req", 32'(tx_req_out), 32'h0);
      check("arst_de", 32'(vid_de), 32'h0);
      check("arst_data", 32'(vid_data), 32'h0);
      check("arst_hsync", 32'(vid_hsync), 32'h0);
      check("arst_vsync", 32'(vid_vsync), 32'h0);
      check("arst_fs", 32'(frame_start), 32'h0);
      check("arst_sticky", 32'(underflow_sticky), 32'h0);
      check("arst_count", 32'(underflow_count), 32'h0);
      exp_q.delete();
      req_n    = 0;
      prev_req = 1'b0;
      hold_all = 1'b0;
      @(negedge tx_clock);
      tx_rst_n = 1'b1;
      wait_frame_start(found, req_at, fs_at);
      check("fs_found_restart", 32'(found), 32'h1);
      check("restart_req_cycle", 32'(req_at), 32'h0);
      run_frame(1'b0, 1'b1, 1'b0);

      // Dense instance has been underflowing on every active pixel since start.
      found = 1'b0;
      for (int i = 0; i < 80000; i++) begin
         if (count2 == 16'hFFFF) begin
            found = 1'b1;
            break;
         end
         @(negedge tx_clock);
      end
      check("sat_reached", 32'(found), 32'h1);
      for (int i = 0; i < 300; i++) @(negedge tx_clock);
      check("sat_count_held", 32'(count2), 32'hFFFF);
      check("sat_sticky", 32'(sticky2), 32'h1);
   endtask

   initial begin
      lines[0] = '{hold: 4'b0000, de: 8'b0000_1111, hs: 8'b0110_0000, vs: 1'b0, uf: 0};
      lines[1] = '{hold: 4'b1110, de: 8'b0000_1111, hs: 8'b0110_0000, vs: 1'b0, uf: 3};
      lines[2] = '{hold: 4'b0000, de: 8'b0000_0000, hs: 8'b0110_0000, vs: 1'b0, uf: 3};
      lines[3] = '{hold: 4'b0000, de: 8'b0000_0000, hs: 8'b0110_0000, vs: 1'b1, uf: 3};
      lines[4] = '{hold: 4'b0000, de: 8'b0000_0000, hs: 8'b0110_0000, vs: 1'b0, uf: 3};

      tx_rst_n      = 1'b0;
      rst2_n        = 1'b0;
      enable        = 1'b0;
      enable2       = 1'b0;
      tx_data       = '0;
      tx_data_valid = 1'b0;
      underflow_clr = 1'b0;

      applyStimulus();
      checkOutput();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
